// File: rtl/collision_detector.sv
// Purpose: scans the stage rectangle table against one player hitbox and publishes a 5-bit contact word.
// Latency: wall/wall_valid update NUM_RECTS+2 cycles after SAMPLE; back-to-back scans every NUM_RECTS+2 cycles.
// Backpressure: table writes are accepted only while idle (cfg_ready = ~busy); the writer holds cfg_we until accepted.
module collision_detector #(
  parameter int NUM_RECTS = 8,
  parameter int PLAYER_W  = 16,
  parameter int PLAYER_H  = 32,
  parameter int MARGIN    = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [31:0]                  position,
  input  logic                         platform_thru,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_RECTS)-1:0] cfg_addr,
  input  logic [63:0]                  cfg_data,
  input  logic                         cfg_platform,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic [31:0]                  wall,
  output logic                         wall_valid,
  output logic                         busy
);

  localparam int AW = $clog2(NUM_RECTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_RECTS - 1);

  // 18-bit signed working width leaves headroom for hitbox size and margin on 16-bit coordinates
  localparam logic signed [17:0] PW = 18'(PLAYER_W);
  localparam logic signed [17:0] PH = 18'(PLAYER_H);
  localparam logic signed [17:0] MG = 18'(MARGIN);

  typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, PUBLISH} state_t;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
  } rect_t;

  function automatic logic signed [17:0] sx(input logic [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [4:0]           acc_q, acc_d;
  logic [31:0]          pos_q, pos_d;
  logic                 thru_q, thru_d;
  logic [4:0]           wall_q, wall_d;
  logic                 wall_valid_q, wall_valid_d;

  rect_t                rect_q [NUM_RECTS];
  rect_t                rect_d [NUM_RECTS];
  logic [NUM_RECTS-1:0] plat_q, plat_d;
  logic [NUM_RECTS-1:0] vld_q, vld_d;

  logic                 cfg_wr;
  rect_t                cur;
  logic                 cur_vld;
  logic                 cur_plat;
  logic signed [17:0]   px, py, rr, tt, x0, y0, x1, y1;
  logic                 hov, vov;
  logic                 c_up, c_down, c_left, c_right;
  logic [4:0]           hit;

  assign busy       = (state_q != IDLE);
  assign cfg_ready  = ~busy;
  assign cfg_wr     = cfg_we & cfg_ready;
  assign wall       = {27'b0, wall_q};
  assign wall_valid = wall_valid_q;

  // Table update: the accepted write replaces one entry, visible to the next scan
  always_comb begin
    rect_d = rect_q;
    plat_d = plat_q;
    vld_d  = vld_q;
    if (cfg_wr) begin
      rect_d[cfg_addr] = cfg_data;
      plat_d[cfg_addr] = cfg_platform;
      vld_d[cfg_addr]  = cfg_valid;
    end
  end

  // Valid bits are reset so a fresh stage starts empty
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Rectangle bounds and type carry no reset; they only matter once their valid bit is set
  always_ff @(posedge clock) begin
    rect_q <= rect_d;
    plat_q <= plat_d;
  end

  // Contact evaluation of the entry currently addressed by the scan index
  always_comb begin
    cur      = rect_q[idx_q];
    cur_vld  = vld_q[idx_q];
    cur_plat = plat_q[idx_q];
    px       = sx(pos_q[31:16]);
    py       = sx(pos_q[15:0]);
    rr       = px + PW;
    tt       = py + PH;
    x0       = sx(cur.x0);
    y0       = sx(cur.y0);
    x1       = sx(cur.x1);
    y1       = sx(cur.y1);
    hov      = (px < x1) && (rr > x0);
    vov      = (py < y1) && (tt > y0);
    c_down   = hov && (py >= y1 - MG) && (py <= y1 + MG);
    c_up     = hov && (tt >= y0 - MG) && (tt <= y0 + MG);
    c_left   = vov && (px >= x1 - MG) && (px <= x1 + MG);
    c_right  = vov && (rr >= x0 - MG) && (rr <= x0 + MG);
    hit      = '0;
    if (cur_vld) begin
      if (cur_plat) begin
        hit[4] = c_down & ~thru_q;
      end else begin
        hit[3:0] = {c_left, c_right, c_down, c_up};
      end
    end
  end

  // Scan sequencer: sample, walk every entry, publish, then repeat while enabled
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    pos_d        = pos_q;
    thru_d       = thru_q;
    wall_d       = wall_q;
    wall_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = SAMPLE;
      end
      SAMPLE: begin
        pos_d   = position;
        thru_d  = platform_thru;
        acc_d   = '0;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        acc_d = acc_q | hit;
        if (idx_q == LAST_IDX) begin
          state_d = PUBLISH;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      PUBLISH: begin
        // wall and its strobe are registered together so wall_valid marks the cycle the new word is visible
        wall_d       = acc_q;
        wall_valid_d = 1'b1;
        state_d      = enable ? SAMPLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state; reset discards any partially accumulated scan
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      pos_q        <= '0;
      thru_q       <= 1'b0;
      wall_q       <= '0;
      wall_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      pos_q        <= pos_d;
      thru_q       <= thru_d;
      wall_q       <= wall_d;
      wall_valid_q <= wall_valid_d;
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
module tb_collision_detector;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] position = '0;
  logic        platform_thru = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [63:0] cfg_data = '0;
  logic        cfg_platform = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] wall;
  logic        wall_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  collision_detector dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .position     (position),
    .platform_thru(platform_thru),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_platform (cfg_platform),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .wall         (wall),
    .wall_valid   (wall_valid),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Waits (bounded) for the wall_valid pulse; n is the number of negedges waited, 0 on timeout
  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (wall_valid) begin
        n = k;
        break;
      end
    end
    if (n == 0) check("valid_timeout", {31'b0, wall_valid}, 32'd1);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] x0, input logic [15:0] y0,
                           input logic [15:0] x1, input logic [15:0] y1, input logic plat);
    cfg_we       = 1'b1;
    cfg_addr     = a;
    cfg_data     = {x0, y0, x1, y1};
    cfg_platform = plat;
    cfg_valid    = 1'b1;
    step();
    cfg_we       = 1'b0;
  endtask

  // Single scan started from idle with a one-cycle enable pulse
  task automatic one_scan(input logic [15:0] x, input logic [15:0] y, input logic thru,
                          input logic [31:0] exp, input string tag);
    int n;
    position      = {x, y};
    platform_thru = thru;
    enable        = 1'b1;
    step();
    enable        = 1'b0;
    wait_valid(n);
    check(tag, wall, exp);
    step();
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (2) step();
    check("rst_wall", wall, 32'd0);
    check("rst_wall_valid", {31'b0, wall_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    reset = 1'b1;
    step();

    // Solid floor, enable held: latency and period
    cfg_write(3'd0, 16'd0, 16'd0, 16'd320, 16'd20, 1'b0);
    position = {16'd100, 16'd20};
    enable   = 1'b1;
    step();
    check("sample_busy", {31'b0, busy}, 32'd1);
    check("sample_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    wait_valid(n);
    check("latency", n, 32'd10);
    check("floor", wall, 32'h02);
    position = {16'd100, 16'd25};
    wait_valid(n);
    check("period", n, 32'd10);
    check("floor_gap", wall, 32'h00);
    enable = 1'b0;
    wait_valid(n);
    check("drain_wall", wall, 32'h00);
    step();
    check("drain_idle", {31'b0, busy}, 32'd0);
    check("pulse_width", {31'b0, wall_valid}, 32'd0);

    // Drop-through platform
    cfg_write(3'd1, 16'd100, 16'd60, 16'd150, 16'd62, 1'b1);
    one_scan(16'd110, 16'd62, 1'b0, 32'h10, "platform");
    one_scan(16'd110, 16'd62, 1'b1, 32'h00, "platform_thru");

    // Side walls
    cfg_write(3'd2, 16'd200, 16'd20, 16'd210, 16'd100, 1'b0);
    one_scan(16'd211, 16'd40, 1'b0, 32'h08, "left_wall");
    one_scan(16'd184, 16'd40, 1'b0, 32'h04, "right_wall");
    one_scan(16'd230, 16'd40, 1'b0, 32'h00, "no_wall");

    // Ceiling and floor at once
    cfg_write(3'd3, 16'd0, 16'd52, 16'd320, 16'd60, 1'b0);
    one_scan(16'd50, 16'd20, 1'b0, 32'h03, "ceil_floor");

    // Write strobe held across a scan is deferred until idle
    position = {16'd50, 16'd20};
    enable   = 1'b1;
    step();
    enable       = 1'b0;
    cfg_we       = 1'b1;
    cfg_addr     = 3'd4;
    cfg_data     = {16'd66, 16'd0, 16'd80, 16'd40};
    cfg_platform = 1'b0;
    cfg_valid    = 1'b1;
    step();
    check("hs_ready_busy", {31'b0, cfg_ready}, 32'd0);
    wait_valid(n);
    check("hs_old_table", wall, 32'h03);
    check("hs_ready_idle", {31'b0, cfg_ready}, 32'd1);
    step();
    cfg_we = 1'b0;
    one_scan(16'd50, 16'd20, 1'b0, 32'h07, "hs_new_entry");

    // Reset in the middle of a scan
    position = {16'd50, 16'd20};
    enable   = 1'b1;
    step();
    repeat (4) step();
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_wall", wall, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("mid_rst_wall_valid", {31'b0, wall_valid}, 32'd0);
    step();
    reset = 1'b1;
    step();
    wait_valid(n);
    check("post_reset_wall", wall, 32'h00);
    enable = 1'b0;
    wait_valid(n);
    step();
    check("post_reset_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Produces the 5-bit contact vector that the player physics block consumes on its `wall` input. It takes that block's `position` output and scans a configurable table of stage rectangles, one rectangle per cycle.
- Each completed scan publishes a registered contact word: ceiling, floor, right wall, left wall, and drop-through platform.
- Sits between the player physics block and the stage configuration logic. There is one instance per player.

Parameters:
- NUM_RECTS, 8: number of stage rectangle entries; address width is clog2(NUM_RECTS).
- PLAYER_W, 16: player hitbox width, in integer pixels.
- PLAYER_H, 32: player hitbox height, in integer pixels.
- MARGIN, 1: contact tolerance in pixels, applied to both sides of an edge.

Ports:
- clock, input, 1: master clock; all state changes on posedge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: when high, scans run back-to-back.
- position, input, 32: {x[31:16], y[15:0]}, signed integer pixels; (x, y) is the hitbox bottom-left corner; y increases upward.
- platform_thru, input, 1: joystick held down; suppresses platform contact.
- cfg_we, input, 1: rectangle table write strobe.
- cfg_addr, input, clog2(NUM_RECTS): table entry to write.
- cfg_data, input, 64: {x0[63:48], y0[47:32], x1[31:16], y1[15:0]}, signed, inclusive bounds, with x0<=x1 and y0<=y1.
- cfg_platform, input, 1: 1 = entry is a drop-through platform; 0 = solid.
- cfg_valid, input, 1: valid bit written into the entry.
- cfg_ready, output, 1: table write accepted this cycle.
- wall, output, 32: bit0 up, bit1 down, bit2 right, bit3 left, bit4 platform_down; bits [31:5] are always 0.
- wall_valid, output, 1: one-cycle pulse when `wall` updates.
- busy, output, 1: scan in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - wall=0, wall_valid=0, busy=0, cfg_ready=1.
  - All entry valid bits clear; rectangle bounds are don't-care.
  - Reset mid-scan discards the partial result; no publish occurs.
- FSM states: IDLE, SAMPLE, SCAN, PUBLISH.
  - IDLE -> SAMPLE when enable=1.
  - SAMPLE: latch position and platform_thru into pos_q and thru_q; clear the accumulator; idx=0.
  - SCAN: evaluate entry idx; OR its contacts into the accumulator; idx++. Go to PUBLISH after idx=NUM_RECTS-1.
  - PUBLISH: wall <= accumulator; wall_valid=1 for this cycle; then SAMPLE if enable=1, else IDLE.
- Timing:
  - Latency from SAMPLE to wall update is NUM_RECTS+2 cycles.
  - Scan period is NUM_RECTS+2 cycles.
  - Dropping enable mid-scan does not abort; the current scan completes and publishes.
- busy is 1 in SAMPLE, SCAN and PUBLISH.
- Table-write handshake:
  - cfg_ready = ~busy.
  - A write happens only when cfg_we & cfg_ready; writes while busy are dropped, and the writer must hold the strobe until cfg_ready.
  - A write lands at the posedge and is visible to the next scan.
- Arithmetic:
  - Sign-extend all coordinates to 18 bits before adding PLAYER_W, PLAYER_H or ±MARGIN. No wrap-around is permitted.
  - Let px,py = pos_q; R = px+PLAYER_W; T = py+PLAYER_H.
  - hov = (px < x1) & (R > x0), strict.
  - vov = (py < y1) & (T > y0), strict.
- Per valid entry:
  - down: hov & (y1-MARGIN <= py <= y1+MARGIN).
  - up: hov & (y0-MARGIN <= T <= y0+MARGIN).
  - left: vov & (x1-MARGIN <= px <= x1+MARGIN).
  - right: vov & (x0-MARGIN <= R <= x0+MARGIN).
  - Solid entry: contributes down to bit1, up to bit0, right to bit2, left to bit3.
  - Platform entry: contributes only down, to bit4, and only if thru_q=0.
- Invalid entries contribute nothing.
- Multiple contacts are ORed. Simultaneous opposite bits (e.g. left and right) are legal and reported as-is.
- Position changes during a scan are ignored; only the value latched in SAMPLE is used.

Test Plan:
- Solid floor only (entry0 = x 0..320, y 0..20, solid). position {100,20}, enable=1 -> wall=0x02 with wall_valid exactly NUM_RECTS+2 cycles after SAMPLE; position {100,25} -> next publish wall=0x00.
- Platform (entry1 = x 100..150, y 60..62, platform). position {110,62}, platform_thru=0 -> wall=0x10; same position with platform_thru=1 -> wall=0x00.
- Side walls (entry2 = x 200..210, y 20..100, solid). position {211,40} -> wall=0x08; position {184,40} -> wall=0x04; position {230,40} -> 0x00.
- Ceiling and floor together: entry3 = x 0..320, y 52..60, solid; position {50,20} (T=52) -> wall=0x03.
- Table-write handshake: cfg_we held during a scan -> cfg_ready=0 and the entry is unchanged; the write lands on the first cycle with cfg_ready=1; the following scan uses the new data.
- Reset mid-SCAN: assert reset at idx=3 -> wall=0, busy=0 immediately, all entries invalid; after release with enable=1 -> wall=0x00.
